// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - host-side NES gamepad serial reader; optional NES_PAD_DEBOUNCE_EN
module nes_pad_reader #(
  parameter int TICK_DIV = 300,
  parameter int POLL_DIV = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_req,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] keycodes,
  output logic       keycodes_valid,
  output logic       busy
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_WAIT, S_CLK_LO, S_CLK_HI, S_DONE
  } state_t;

  state_t          state, next_state;
  logic [TW-1:0]   tick_cnt;
  logic [PW-1:0]   poll_cnt;
  logic            poll_due;
  logic            latch_second;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [1:0]      data_sync;
  logic            sample;
  logic            tick_end;
  logic            poll_wrap;
  logic            start;
  logic            write_en;
  logic            latch_d;
  logic            clk_d;
  logic            busy_d;

  // Pad drives data low for a pressed button
  assign sample    = ~data_sync[1];
  assign tick_end  = (tick_cnt == TICK_LAST);
  assign poll_wrap = (poll_cnt == POLL_LAST);
  assign start     = (state == S_IDLE) && (poll_due || poll_req);

`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0] prev_raw;

  assign write_en = (state == S_DONE) && (shift == prev_raw);

  always_ff @(posedge clk) begin
    if (reset)
      prev_raw <= 8'h00;
    else if (state == S_DONE)
      prev_raw <= shift;
  end
`else
  assign write_en = (state == S_DONE);
`endif

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LATCH;
      S_LATCH:  if (tick_end && latch_second) next_state = S_WAIT;
      S_WAIT:   if (tick_end) next_state = S_CLK_LO;
      S_CLK_LO: if (tick_end) next_state = S_CLK_HI;
      S_CLK_HI: if (tick_end) next_state = (bit_idx == 3'd7) ? S_DONE : S_CLK_LO;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so the registered pins line up with it
  always_comb begin
    latch_d = 1'b0;
    clk_d   = 1'b1;
    busy_d  = 1'b1;
    case (next_state)
      S_IDLE:   busy_d  = 1'b0;
      S_LATCH:  latch_d = 1'b1;
      S_CLK_LO: clk_d   = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      pad_latch      <= 1'b0;
      pad_clk        <= 1'b1;
      busy           <= 1'b0;
      data_sync      <= 2'b11;
      tick_cnt       <= '0;
      latch_second   <= 1'b0;
    end else begin
      state          <= next_state;
      pad_latch      <= latch_d;
      pad_clk        <= clk_d;
      busy           <= busy_d;
      data_sync      <= {data_sync[0], pad_data};
      if (state == S_IDLE || next_state != state || tick_end)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + TW'(1);
      latch_second <= (state == S_LATCH) && (latch_second || tick_end);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt <= '0;
      poll_due <= 1'b0;
    end else begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
      if (start)
        poll_due <= 1'b0;
      else if (poll_wrap)
        poll_due <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx        <= 3'd0;
      shift          <= 8'h00;
      keycodes       <= 8'h00;
      keycodes_valid <= 1'b0;
    end else begin
      if (state == S_WAIT && tick_end) begin
        shift[0] <= sample;
        bit_idx  <= 3'd1;
      end else if (state == S_CLK_HI && tick_end) begin
        shift[bit_idx] <= sample;
        bit_idx        <= bit_idx + 3'd1;
      end
      keycodes_valid <= write_en;
      if (write_en)
        keycodes <= shift;
    end
  end
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb/tb_nes_pad_reader.sv - randomized self-checking bench for nes_pad_reader
module tb_nes_pad_reader;
  localparam int T = 4;
`ifdef NES_PAD_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, poll_req, pad_data;
  logic       pad_latch, pad_clk, keycodes_valid, busy;
  logic [7:0] keycodes;
  logic       reset_b, pad_latch_b, pad_clk_b, kv_b, busy_b;
  logic [7:0] kc_b;

  logic [7:0] buttons = 8'h00;
  logic       connected = 1'b1;
  int         pad_idx = 8;
  logic [7:0] m_kc, m_prev;
  int         n_checks = 0;
  int         n_pass = 0;

  nes_pad_reader #(.TICK_DIV(T), .POLL_DIV(50000)) u_dut (
    .clk(clk), .reset(reset), .poll_req(poll_req), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .keycodes(keycodes),
    .keycodes_valid(keycodes_valid), .busy(busy)
  );

  nes_pad_reader #(.TICK_DIV(T), .POLL_DIV(200)) u_auto (
    .clk(clk), .reset(reset_b), .poll_req(1'b0), .pad_data(1'b1),
    .pad_latch(pad_latch_b), .pad_clk(pad_clk_b), .keycodes(kc_b),
    .keycodes_valid(kv_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Pad: latch reloads bit 0, each rising pad_clk presents the next button
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_idx = 0;
    else           pad_idx = pad_idx + 1;
  end
  assign pad_data = !connected ? 1'b1 : (pad_idx < 8) ? ~buttons[pad_idx] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_poll(input string tag, input logic [7:0] btn, input bit conn, input bit extra);
    logic [7:0] raw;
    bit   exp_v;
    int   lat_hi = 0, lat_rise = 0, clk_fall = 0, run = 0, bad_w = 0, v_cnt = 0, v_k = -1;
    logic prev_l = 1'b0, prev_c = 1'b1;
    raw   = conn ? btn : 8'h00;
    exp_v = !DEB || (raw == m_prev);
    if (exp_v) m_kc = raw;
    m_prev = raw;
    @(negedge clk);
    buttons   = btn;
    connected = conn;
    poll_req  = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      @(posedge clk); #1;
      if (k == 1) poll_req = 1'b0;
      if (extra && k == 20) poll_req = 1'b1;
      if (extra && k == 21) poll_req = 1'b0;
      if (pad_latch) lat_hi++;
      if (pad_latch && !prev_l) lat_rise++;
      if (!pad_clk) run++;
      if (!pad_clk && prev_c) clk_fall++;
      if (pad_clk && !prev_c && run != T) bad_w++;
      if (pad_clk) run = 0;
      if (keycodes_valid) begin v_cnt++; v_k = k - 1; end
      prev_l = pad_latch;
      prev_c = pad_clk;
    end
    check({tag, "_latch_len"}, lat_hi, 2 * T);
    check({tag, "_latch_rises"}, lat_rise, 1);
    check({tag, "_clk_pulses"}, clk_fall, 7);
    check({tag, "_clk_width_bad"}, bad_w, 0);
    check({tag, "_valid_cnt"}, v_cnt, exp_v ? 1 : 0);
    check({tag, "_keycodes"}, keycodes, m_kc);
    check({tag, "_busy_end"}, busy, 1'b0);
    if (exp_v) check({tag, "_latency"}, v_k, 17 * T + 1);
  endtask

  task automatic reset_mid_poll();
    @(negedge clk);
    buttons   = 8'hA5;
    connected = 1'b1;
    poll_req  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 1) poll_req = 1'b0;
    end
    check("rst_in_clk_lo", pad_clk, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_latch", pad_latch, 1'b0);
    check("rst_clk", pad_clk, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_keycodes", keycodes, 8'h00);
    check("rst_valid", keycodes_valid, 1'b0);
    reset  = 1'b0;
    m_kc   = 8'h00;
    m_prev = 8'h00;
  endtask

  task automatic auto_poll_check();
    int   rises[$];
    int   valids[$];
    logic prev_l = pad_latch_b;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (pad_latch_b && !prev_l) rises.push_back(k);
      if (kv_b) valids.push_back(k);
      prev_l = pad_latch_b;
    end
    check("auto_rise_count_ge4", rises.size() >= 4, 1'b1);
    check("auto_keycodes", kc_b, 8'h00);
    for (int i = 1; i < rises.size(); i++)
      check("auto_interval", rises[i] - rises[i-1], 200);
    foreach (rises[i]) begin
      if (rises[i] + 75 < 1000) begin
        int n = 0;
        int at = -1;
        foreach (valids[j])
          if (valids[j] > rises[i] && valids[j] < rises[i] + 200) begin
            n++;
            at = valids[j];
          end
        check("auto_valid_per_poll", n, 1);
        check("auto_valid_pos", at - rises[i], 17 * T + 1);
      end
    end
  endtask

  initial begin
    logic [7:0] last, b;
    reset = 1'b1; reset_b = 1'b1; poll_req = 1'b0;
    m_kc = 8'h00; m_prev = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_keycodes", keycodes, 8'h00);
    check("reset_valid", keycodes_valid, 1'b0);
    check("reset_latch", pad_latch, 1'b0);
    check("reset_clk", pad_clk, 1'b1);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0; reset_b = 1'b0;

    run_poll("a_start", 8'h09, 1'b1, 1'b0);
    run_poll("a_start_again", 8'h09, 1'b1, 1'b0);
    run_poll("disconnected", 8'hFF, 1'b0, 1'b0);
    run_poll("req_while_busy", 8'h5A, 1'b1, 1'b1);
    run_poll("deb_01a", 8'h01, 1'b1, 1'b0);
    run_poll("deb_01b", 8'h01, 1'b1, 1'b0);
    run_poll("deb_02", 8'h02, 1'b1, 1'b0);
    run_poll("deb_04", 8'h04, 1'b1, 1'b0);
    last = 8'h04;
    for (int i = 0; i < 10; i++) begin
      b = ($urandom_range(0, 1) == 1) ? last : 8'($urandom);
      run_poll("random", b, 1'b1, 1'b0);
      last = b;
    end
    reset_mid_poll();
    run_poll("post_reset", 8'h81, 1'b1, 1'b0);
    run_poll("post_reset2", 8'h81, 1'b1, 1'b0);
    auto_poll_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Console-side reader for a physical NES gamepad: drives the pad's latch and clock pins, samples its serial data line, and presents the 8 button states as a parallel byte. It sits between the board GPIO and the `keycodes_in` port of the memory-mapped $4016 controller register block. That register block is the device end of the same shift-register protocol; this block is the host end. It polls autonomously at a fixed rate, or on request.

## Interface
- `TICK_DIV`, 300: clk cycles per protocol tick (6 µs at 50 MHz); must be ≥ 4.
- `POLL_DIV`, 833333: clk cycles between automatic poll starts (~60 Hz at 50 MHz); must be > 17*TICK_DIV + 4.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `poll_req`  in  1  one-cycle request to start a poll immediately.
- `pad_data`  in  1  serial data from pad, active-low, asynchronous.
- `pad_latch`  out  1  latch/strobe to pad, active-high.
- `pad_clk`  out  1  shift clock to pad; idles high, pulses low.
- `keycodes`  out  8  button states, 1 = pressed: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- `keycodes_valid`  out  1  one-cycle pulse when `keycodes` is written.
- `busy`  out  1  high while a poll is in progress (any state except IDLE).

## Operation
- `pad_data` passes through a 2-flop synchronizer. All samples use the synchronized value, inverted.
- Tick counter: counts 0..TICK_DIV-1 in non-IDLE states. It is cleared on every state entry. "Tick end" means the cycle where count = TICK_DIV-1.
- Poll counter: free-running 0..POLL_DIV-1 from reset. On wrap it raises `poll_due`. `poll_due` clears when a poll starts.
- FSM states:
  - IDLE: `pad_latch`=0, `pad_clk`=1. Goes to LATCH when `poll_due` or `poll_req`.
  - LATCH: `pad_latch`=1 for 2 ticks, then goes to WAIT.
  - WAIT: `pad_latch`=0 for 1 tick. At tick end it samples bit 0 into shift[0], sets bit index to 1, and goes to CLK_LO.
  - CLK_LO: `pad_clk`=0 for 1 tick, then goes to CLK_HI.
  - CLK_HI: `pad_clk`=1 for 1 tick. At tick end it samples into shift[index] and increments the index. After index 7 it goes to DONE; otherwise it goes to CLK_LO.
  - DONE: 1 cycle. Writes `keycodes` from shift, pulses `keycodes_valid`, then returns to IDLE.
- Exactly 7 low pulses are driven on `pad_clk` per poll.
- `poll_req` while `busy` is ignored and not queued.
- `poll_req` in the same cycle as `poll_due` starts a single poll.
- A disconnected pad reads data high (pull-up), which decodes to `keycodes` = 8'h00.
- Reset at any point, including mid-poll, returns to IDLE on the next edge. The partial shift data is discarded.

## Timing
- Reset values: `pad_latch`=0, `pad_clk`=1, `keycodes`=8'h00, `keycodes_valid`=0, `busy`=0. Poll counter, tick counter and shift register are 0.
- All outputs are registered and glitch-free.
- Start latency: `pad_latch` rises 1 cycle after `poll_req` is sampled high in IDLE.
- `pad_latch` high: exactly 2*TICK_DIV cycles. Each `pad_clk` low pulse: exactly TICK_DIV cycles.
- Poll length, from `pad_latch` rise to the DONE cycle: 17*TICK_DIV cycles. `keycodes_valid` is high in the cycle after DONE.
- Data sample point: each tick end. The synchronizer adds 2 cycles of lag, which is covered by TICK_DIV ≥ 4.
- `keycodes` holds its value between writes.

## Configuration
- `NES_PAD_DEBOUNCE_EN` defined:
  - At DONE, the shift result is compared with the previous poll's raw result.
  - `keycodes` is written, and `keycodes_valid` pulses, only when the two match.
  - The previous raw result resets to 8'h00.
- Undefined: every completed poll writes `keycodes` and pulses `keycodes_valid`.

## Test plan
- Reset mid-poll (assert during CLK_LO) -> next cycle `pad_latch`=0, `pad_clk`=1, `busy`=0, `keycodes`=8'h00.
- TICK_DIV=4, pad model returns A+Start (serial low at bits 0,3), `poll_req` pulse -> `pad_latch` high 8 cycles, 7 low `pad_clk` pulses of 4 cycles, `keycodes`=8'h09, single valid pulse 69 cycles after `poll_req`.
- Pad model all released / disconnected (data held high) -> `keycodes`=8'h00 after poll.
- `poll_req` pulsed again while `busy` -> no extra latch pulse; exactly one `keycodes_valid`.
- POLL_DIV=200, no `poll_req` -> a latch rise every 200 cycles, one valid pulse per poll.
- With `NES_PAD_DEBOUNCE_EN`, pad pattern 8'h01 then 8'h01 -> no update after the first poll; `keycodes`=8'h01 after the second. Pattern 8'h02 then 8'h04 -> `keycodes` unchanged.
